key_event_arbiter: RTL and testbench

//   Collects one-cycle key_pulse outputs from NUM_KEYS KeyDebounce instances (entry, exit, admin

---
 rtl/key_event_arbiter_pkg.sv | 21 ++
 rtl/key_evt_rr_pick.sv | 31 +++
 rtl/key_event_arbiter.sv | 124 ++++++++++++
 tb/tb_key_event_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_arbiter_pkg.sv
// Shared definitions for the parking-panel key event arbiter: default sizing,
// the panel's key indices and a small index-wrap helper.
package key_event_arbiter_pkg;

    localparam int DEF_NUM_KEYS   = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // Key positions on the panel, as wired into key_pulse.
    typedef enum logic [1:0] {
        KEY_ENTRY     = 2'd0,
        KEY_EXIT      = 2'd1,
        KEY_RESET_CNT = 2'd2,
        KEY_ADMIN     = 2'd3
    } key_id_e;

    // Next index in a ring of n positions.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/key_evt_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit starting
// at rr_ptr and wrapping around the key ring.
module key_evt_rr_pick
    import key_event_arbiter_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int CODE_W   = 2
) (
    input  logic [NUM_KEYS-1:0] req,
    input  logic [CODE_W-1:0]   rr_ptr,
    output logic                grant_valid,
    output logic [CODE_W-1:0]   grant_idx
);

    logic [CODE_W-1:0] idx;

    // Scan from the farthest offset back to rr_ptr so the nearest request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            idx = CODE_W'((int'(rr_ptr) + k) % NUM_KEYS);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Key event arbiter: latches one-cycle key pulses as pending, grants them
// round-robin into a show-ahead FIFO and presents the head over valid/ready.
module key_event_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CODE_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           key_pulse,
    input  logic                          clr_overflow,
    output logic                          evt_valid,
    output logic [CODE_W-1:0]             evt_code,
    input  logic                          evt_ready,
    output logic [NUM_KEYS-1:0]           pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CODE_W-1:0]   rr_ptr;
    logic                grant_valid;
    logic [CODE_W-1:0]   grant_idx;
    logic [NUM_KEYS-1:0] grant_mask;
    logic                room;
    logic                push;
    logic                pop;
    logic                merge;

    logic [CODE_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CODE_W-1:0]   last_code;

    key_evt_rr_pick #(
        .NUM_KEYS (NUM_KEYS),
        .CODE_W   (CODE_W)
    ) u_pick (
        .req         (pending),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A slot frees up this edge if the FIFO is not full or the head is leaving.
    assign evt_valid  = (count != '0);
    assign pop        = evt_valid & evt_ready;
    assign room       = (count < CNT_W'(FIFO_DEPTH)) | pop;
    assign push       = room & grant_valid;
    assign fifo_count = count;

    // Show-ahead head; when empty keep showing the last delivered code.
    assign evt_code = evt_valid ? mem[rd_ptr] : last_code;

    // One-hot of the key granted this edge; a pulse on it starts a fresh pending event.
    always_comb begin
        grant_mask = '0;
        if (push) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    assign merge = |(key_pulse & pending & ~grant_mask);

    // Pending latch and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            rr_ptr  <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | key_pulse;
            if (push) begin
                rr_ptr <= CODE_W'(wrap_inc(int'(grant_idx), NUM_KEYS));
            end
        end
    end

    // Sticky overflow: a merge on the same edge beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (merge) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // FIFO pointers, occupancy and last-delivered code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_code <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_code <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; only read while occupied, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with hand-computed expectations.
module tb_key_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] key_pulse;
    logic       clr_overflow;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic [3:0] pending;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_cmp;
    int n_err;

    key_event_arbiter #(
        .NUM_KEYS   (4),
        .FIFO_DEPTH (4),
        .CODE_W     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pulse    (key_pulse),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ready    (evt_ready),
        .pending      (pending),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        key_pulse    = 4'b0000;
        clr_overflow = 1'b0;
        evt_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        key_pulse    = 4'b0000;
        clr_overflow = 1'b0;
        evt_ready    = 1'b0;

        // Reset state
        do_reset();
        check_val("rst_valid",    32'(evt_valid),  0);
        check_val("rst_pending",  32'(pending),    0);
        check_val("rst_count",    32'(fifo_count), 0);
        check_val("rst_overflow", 32'(overflow),   0);
        check_val("rst_code",     32'(evt_code),   0);

        // Single pulse on key 2
        evt_ready = 1'b1;
        key_pulse = 4'b0100;
        tick();
        key_pulse = 4'b0000;
        check_val("t1_pending", 32'(pending), 4);
        check_val("t1_valid0",  32'(evt_valid), 0);
        tick();
        check_val("t1_valid1", 32'(evt_valid), 1);
        check_val("t1_code",   32'(evt_code), 2);
        check_val("t1_count",  32'(fifo_count), 1);
        tick();
        check_val("t1_valid2",  32'(evt_valid), 0);
        check_val("t1_codehold", 32'(evt_code), 2);

        // Keys 0,1,3 together from rr_ptr=0, then wrap behaviour
        do_reset();
        evt_ready = 1'b1;
        key_pulse = 4'b1011;
        tick();
        key_pulse = 4'b0000;
        check_val("t2_pending", 32'(pending), 11);
        tick();
        check_val("t2_v0", 32'(evt_valid), 1);
        check_val("t2_c0", 32'(evt_code), 0);
        tick();
        check_val("t2_c1", 32'(evt_code), 1);
        tick();
        check_val("t2_c3", 32'(evt_code), 3);
        tick();
        check_val("t2_empty", 32'(evt_valid), 0);
        key_pulse = 4'b0101;
        tick();
        key_pulse = 4'b0000;
        tick();
        check_val("t2_w0", 32'(evt_code), 0);
        tick();
        check_val("t2_w2", 32'(evt_code), 2);
        // rr_ptr now 3: key 3 must beat key 0
        key_pulse = 4'b1001;
        tick();
        key_pulse = 4'b0000;
        check_val("t2_empty2", 32'(evt_valid), 0);
        tick();
        check_val("t2_r3", 32'(evt_code), 3);
        tick();
        check_val("t2_r0", 32'(evt_code), 0);
        tick();
        check_val("t2_empty3", 32'(evt_valid), 0);

        // Fill with ready low, one pending left, then drain (push+pop while full)
        do_reset();
        key_pulse = 4'b1111;
        tick();
        key_pulse = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        check_val("t3_full", 32'(fifo_count), 4);
        key_pulse = 4'b0001;
        tick();
        key_pulse = 4'b0000;
        check_val("t3_count",   32'(fifo_count), 4);
        check_val("t3_pending", 32'(pending), 1);
        check_val("t3_ovf",     32'(overflow), 0);
        check_val("t3_head",    32'(evt_code), 0);
        evt_ready = 1'b1;
        tick();
        check_val("t3_pp_count", 32'(fifo_count), 4);
        check_val("t3_pp_pend",  32'(pending), 0);
        check_val("t3_d1",       32'(evt_code), 1);
        tick();
        check_val("t3_d2",  32'(evt_code), 2);
        check_val("t3_cnt3", 32'(fifo_count), 3);
        tick();
        check_val("t3_d3", 32'(evt_code), 3);
        tick();
        check_val("t3_d0", 32'(evt_code), 0);
        check_val("t3_dv", 32'(evt_valid), 1);
        tick();
        check_val("t3_empty", 32'(evt_valid), 0);

        // Repeat pulse on a waiting key while full, overflow set/clear
        do_reset();
        key_pulse = 4'b1111;
        tick();
        key_pulse = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        key_pulse = 4'b0010;
        tick();
        check_val("t4_pend1", 32'(pending), 2);
        check_val("t4_ovf0",  32'(overflow), 0);
        tick();
        key_pulse = 4'b0000;
        check_val("t4_ovf1",  32'(overflow), 1);
        check_val("t4_pend2", 32'(pending), 2);
        check_val("t4_count", 32'(fifo_count), 4);
        key_pulse    = 4'b0010;
        clr_overflow = 1'b1;
        tick();
        key_pulse = 4'b0000;
        check_val("t4_setwins", 32'(overflow), 1);
        tick();
        clr_overflow = 1'b0;
        check_val("t4_clr", 32'(overflow), 0);
        evt_ready = 1'b1;
        tick();
        check_val("t4_pp_count", 32'(fifo_count), 4);
        check_val("t4_h1",       32'(evt_code), 1);
        tick();
        tick();
        tick();
        check_val("t4_last1", 32'(evt_code), 1);
        tick();
        check_val("t4_empty", 32'(evt_valid), 0);

        // Async reset with 3 queued + 2 pending
        do_reset();
        key_pulse = 4'b0111;
        tick();
        key_pulse = 4'b0000;
        tick();
        tick();
        key_pulse = 4'b1001;
        tick();
        key_pulse = 4'b0000;
        check_val("t6_count3", 32'(fifo_count), 3);
        check_val("t6_pend",   32'(pending), 9);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_valid",   32'(evt_valid), 0);
        check_val("t6_pending", 32'(pending), 0);
        check_val("t6_count",   32'(fifo_count), 0);
        check_val("t6_ovf",     32'(overflow), 0);
        tick();
        rst       = 1'b0;
        evt_ready = 1'b1;
        key_pulse = 4'b1000;
        tick();
        key_pulse = 4'b0000;
        check_val("t6_p3", 32'(pending), 8);
        tick();
        check_val("t6_v3", 32'(evt_valid), 1);
        check_val("t6_c3", 32'(evt_code), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
